// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Package : md_pkg
// Shared types and constants for the multiply/divide issue controller:
//   - md_op_t       : E-stage multiply/divide instruction class encoding
//   - MD_BIT_*      : bit positions inside the 5-bit md_ctrl vector
//   - MD_*_LAT_DEF  : default unit latencies (launch edge to commit)
//   - md_state_t    : issue FSM states
// Revision: 1.0 - initial release
// ============================================================================
package md_pkg;

  localparam int MD_CNT_W = 4;

  localparam int MD_MUL_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF = 10;

  // Bit positions in md_ctrl.
  localparam int MD_BIT_LO       = 0;
  localparam int MD_BIT_MOVE     = 1;
  localparam int MD_BIT_UNSIGNED = 2;
  localparam int MD_BIT_DIVIDE   = 3;
  localparam int MD_BIT_LAUNCH   = 4;

  typedef enum logic [3:0] {
    MD_OP_NONE  = 4'd0,
    MD_OP_MULT  = 4'd1,
    MD_OP_MULTU = 4'd2,
    MD_OP_DIV   = 4'd3,
    MD_OP_DIVU  = 4'd4,
    MD_OP_MFHI  = 4'd5,
    MD_OP_MFLO  = 4'd6,
    MD_OP_MTHI  = 4'd7,
    MD_OP_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_latency_counter.sv
`default_nettype none
// ============================================================================
// Module  : md_latency_counter
// Remaining-latency counter for the multiply/divide unit.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   load        : load load_val (highest priority after clear)
//   load_val    : latency to load
//   dec         : decrement by one
//   clear       : force to zero (abort)
//   count       : current remaining latency
//   last        : count == 1, i.e. this is the commit cycle
// Revision: 1.0 - initial release
// ============================================================================
module md_latency_counter
  import md_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  input  logic                dec,
  input  logic                clear,
  output logic [MD_CNT_W-1:0] count,
  output logic                last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == MD_CNT_W'(1));

endmodule : md_latency_counter
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : md_issue_ctrl
// E-stage issue controller in front of the HI/LO multiply/divide unit.
// Decodes the E-stage md class into the unit's control vector, owns the
// unit's latency counter, and stalls D for any following md instruction
// while the unit is busy.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   e_valid, e_op, e_flush : E-stage instruction, class and squash
//   revoke_in              : abort the in-flight operation
//   d_is_md                : D-stage instruction is an md-class instruction
//   md_ctrl                : {launch, divide, unsigned, move, lo}
//   md_calculate           : result-commit strobe
//   md_revoke              : abort strobe to the unit
//   md_load_hi/md_load_lo  : mthi/mtlo write enables
//   stall_d                : hold D stage
//   count                  : remaining latency
//   proto_err              : sticky protocol error (launch/move while busy)
// Revision: 1.0 - initial release
// ============================================================================
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = MD_MUL_LAT_DEF,
  parameter int DIV_LAT = MD_DIV_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                e_valid,
  input  logic [3:0]          e_op,
  input  logic                e_flush,
  input  logic                revoke_in,
  input  logic                d_is_md,
  output logic [4:0]          md_ctrl,
  output logic                md_calculate,
  output logic                md_revoke,
  output logic                md_load_hi,
  output logic                md_load_lo,
  output logic                stall_d,
  output logic [MD_CNT_W-1:0] count,
  output logic                proto_err
);

  md_state_t state, state_next;

  logic                ev;
  logic [3:0]          op_eff;
  logic [4:0]          raw_ctrl;
  logic                raw_load_hi;
  logic                raw_load_lo;
  logic                busy;
  logic                launch;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_clear;
  logic                cnt_last;
  logic [MD_CNT_W-1:0] cnt_load_val;
  logic                err_set;

  // A flushed or invalid E slot behaves exactly like NONE.
  assign ev     = e_valid & ~e_flush;
  assign op_eff = ev ? e_op : MD_OP_NONE;
  assign busy   = (state == MD_BUSY);

  // Raw decode, before the BUSY suppression of the launch bit.
  always_comb begin
    raw_ctrl    = 5'b00000;
    raw_load_hi = 1'b0;
    raw_load_lo = 1'b0;
    case (op_eff)
      MD_OP_MULT:  raw_ctrl = 5'b10000;
      MD_OP_MULTU: raw_ctrl = 5'b10100;
      MD_OP_DIV:   raw_ctrl = 5'b11000;
      MD_OP_DIVU:  raw_ctrl = 5'b11100;
      MD_OP_MFHI:  raw_ctrl = 5'b00010;
      MD_OP_MFLO:  raw_ctrl = 5'b00011;
      MD_OP_MTHI: begin
        raw_ctrl    = 5'b00010;
        raw_load_hi = 1'b1;
      end
      MD_OP_MTLO: begin
        raw_ctrl    = 5'b00011;
        raw_load_lo = 1'b1;
      end
      default:     raw_ctrl = 5'b00000;
    endcase
  end

  assign cnt_load_val = raw_ctrl[MD_BIT_DIVIDE] ? MD_CNT_W'(DIV_LAT)
                                                : MD_CNT_W'(MUL_LAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and all combinational outputs; everything is held at zero
  // while reset is asserted so nothing leaks to the unit during reset.
  always_comb begin
    state_next   = state;
    launch       = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_clear    = 1'b0;
    err_set      = 1'b0;
    md_ctrl      = 5'b00000;
    md_calculate = 1'b0;
    md_revoke    = 1'b0;
    md_load_hi   = 1'b0;
    md_load_lo   = 1'b0;
    stall_d      = 1'b0;

    if (!reset) begin
      launch                 = raw_ctrl[MD_BIT_LAUNCH] & ~busy;
      md_ctrl                = raw_ctrl;
      md_ctrl[MD_BIT_LAUNCH] = launch;
      // Illegal moves while busy still pulse the loads; they only flag.
      md_load_hi             = raw_load_hi;
      md_load_lo             = raw_load_lo;
      md_calculate           = busy & cnt_last & ~revoke_in;
      md_revoke              = busy & revoke_in;
      stall_d                = d_is_md & (busy | launch);
      err_set                = busy & (raw_ctrl[MD_BIT_LAUNCH] | raw_load_hi | raw_load_lo);

      case (state)
        MD_IDLE: begin
          if (launch) begin
            state_next = MD_BUSY;
            cnt_load   = 1'b1;
          end
        end
        MD_BUSY: begin
          if (revoke_in) begin
            state_next = MD_IDLE;
            cnt_clear  = 1'b1;
          end else begin
            cnt_dec = 1'b1;
            if (cnt_last) begin
              state_next = MD_IDLE;
            end
          end
        end
        default: state_next = MD_IDLE;
      endcase
    end
  end

  md_latency_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .clear    (cnt_clear),
    .count    (count),
    .last     (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (err_set) begin
      proto_err <= 1'b1;
    end
  end

endmodule : md_issue_ctrl
`default_nettype wire
